// File: rtl/max30003_pkg.sv
// MAX30003 SPI responder shared definitions.
// Register map, FIFO tag codes and frame FSM encoding.
package max30003_pkg;

  localparam logic [6:0] ADDR_SW_RST     = 7'h08;
  localparam logic [6:0] ADDR_SYNCH      = 7'h09;
  localparam logic [6:0] ADDR_CNFG_GEN   = 7'h10;
  localparam logic [6:0] ADDR_CNFG_CAL   = 7'h12;
  localparam logic [6:0] ADDR_CNFG_EMUX  = 7'h14;
  localparam logic [6:0] ADDR_CNFG_ECG   = 7'h15;
  localparam logic [6:0] ADDR_CNFG_RTOR1 = 7'h1D;
  localparam logic [6:0] ADDR_ECG_FIFO   = 7'h21;
  localparam logic [6:0] ADDR_RTOR       = 7'h25;

  localparam logic [2:0] ETAG_VALID = 3'b000;
  localparam logic [2:0] ETAG_EMPTY = 3'b110;
  localparam logic [2:0] ETAG_OVF   = 3'b111;
  localparam logic [2:0] PTAG_NONE  = 3'b111;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CMD     = 2'd1;
  localparam logic [1:0] ST_DATA    = 2'd2;
  localparam logic [1:0] ST_WAIT_CS = 2'd3;

  localparam int GEN_EN_ECG_BIT = 19;

  function automatic logic [23:0] ecg_word(
    input logic [17:0] smp,
    input logic [2:0]  etag
  );
    return {smp, etag, PTAG_NONE};
  endfunction

endpackage

// File: rtl/max30003_ecg_fifo.sv
// ECG sample FIFO: synchronous, power-of-two depth,
// flush has priority; a pop frees room for a same-cycle push.
module max30003_ecg_fifo
  import max30003_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [17:0]   wdata,
  output logic [17:0]   rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [17:0]   mem_q [DEPTH];
  logic [17:0]   mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = wdata;
        wptr_d = wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/max30003_spi_responder.sv
// MAX30003-style SPI register responder (mode 0, 32-bit frames)
// with config regs, RTOR capture and an ECG sample FIFO.
module max30003_spi_responder
  import max30003_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sclk,
  input  logic          cs,
  input  logic          mosi,
  output logic          miso,
  input  logic          smp_valid,
  input  logic [17:0]   smp_data,
  input  logic          rtor_valid,
  input  logic [13:0]   rtor_data,
  output logic [CW-1:0] fifo_count,
  output logic          fifo_ovf,
  output logic          frame_err
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES:0]   sclk_cat, cs_cat, mosi_cat;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_prev_q, cs_prev_q;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [1:0]  state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] sh_q, sh_d;
  logic [6:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [23:0] rd_sh_q, rd_sh_d;
  logic        miso_q, miso_d;
  logic        frame_err_q, frame_err_d;

  logic [23:0] gen_q, gen_d, cal_q, cal_d, emux_q, emux_d;
  logic [23:0] ecg_q, ecg_d, rtor1_q, rtor1_d, rtor_q, rtor_d;
  logic        ovf_q, ovf_d;

  logic        wr_en, pop, push, flush;
  logic [23:0] wdata, rd_word;
  logic [17:0] fifo_rdata;
  logic        fifo_full, fifo_empty;

  assign sclk_cat    = {sclk_sync_q, sclk};
  assign cs_cat      = {cs_sync_q, cs};
  assign mosi_cat    = {mosi_sync_q, mosi};
  assign sclk_sync_d = sclk_cat[SYNC_STAGES-1:0];
  assign cs_sync_d   = cs_cat[SYNC_STAGES-1:0];
  assign mosi_sync_d = mosi_cat[SYNC_STAGES-1:0];

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  assign wdata = {sh_q[22:0], mosi_s};
  assign push  = smp_valid && gen_q[GEN_EN_ECG_BIT];

  // Read mux is keyed on the address bits shifted in so far,
  // so it is valid at the 8th rising edge when rd_sh is loaded.
  always_comb begin
    rd_word = '0;
    case (sh_q[6:0])
      ADDR_CNFG_GEN:   rd_word = gen_q;
      ADDR_CNFG_CAL:   rd_word = cal_q;
      ADDR_CNFG_EMUX:  rd_word = emux_q;
      ADDR_CNFG_ECG:   rd_word = ecg_q;
      ADDR_CNFG_RTOR1: rd_word = rtor1_q;
      ADDR_RTOR:       rd_word = rtor_q;
      ADDR_ECG_FIFO: begin
        if (ovf_q)
          rd_word = ecg_word(18'd0, ETAG_OVF);
        else if (fifo_empty)
          rd_word = ecg_word(18'd0, ETAG_EMPTY);
        else
          rd_word = ecg_word(fifo_rdata, ETAG_VALID);
      end
      default:         rd_word = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    rd_sh_d     = rd_sh_q;
    miso_d      = miso_q;
    frame_err_d = 1'b0;
    wr_en       = 1'b0;
    pop         = 1'b0;
    if (cs_rise) begin
      state_d     = ST_IDLE;
      miso_d      = 1'b0;
      frame_err_d = (state_q == ST_CMD) || (state_q == ST_DATA);
    end else begin
      case (state_q)
        ST_IDLE: begin
          miso_d = 1'b0;
          if (cs_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
            sh_d      = '0;
          end
        end
        ST_CMD: begin
          miso_d = 1'b0;
          if (sclk_rise && !cs_s) begin
            sh_d      = {sh_q[22:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 5'd7) begin
              state_d = ST_DATA;
              addr_d  = sh_q[6:0];
              rw_d    = mosi_s;
              rd_sh_d = mosi_s ? rd_word : '0;
            end
          end
        end
        ST_DATA: begin
          if (sclk_rise && !cs_s) begin
            sh_d      = {sh_q[22:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 5'd31) begin
              state_d = ST_WAIT_CS;
              miso_d  = 1'b0;
              wr_en   = !rw_q;
              pop     = rw_q && (addr_q == ADDR_ECG_FIFO)
                        && !fifo_empty;
            end
          end else if (sclk_fall) begin
            miso_d  = rd_sh_q[23];
            rd_sh_d = {rd_sh_q[22:0], 1'b0};
          end
        end
        ST_WAIT_CS: miso_d = 1'b0;
        default: begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    gen_d   = gen_q;
    cal_d   = cal_q;
    emux_d  = emux_q;
    ecg_d   = ecg_q;
    rtor1_d = rtor1_q;
    rtor_d  = rtor_q;
    ovf_d   = ovf_q;
    flush   = 1'b0;
    if (rtor_valid) rtor_d = {rtor_data, 10'b0};
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    if (wr_en) begin
      case (addr_q)
        ADDR_CNFG_GEN:   gen_d   = wdata;
        ADDR_CNFG_CAL:   cal_d   = wdata;
        ADDR_CNFG_EMUX:  emux_d  = wdata;
        ADDR_CNFG_ECG:   ecg_d   = wdata;
        ADDR_CNFG_RTOR1: rtor1_d = wdata;
        ADDR_SW_RST: begin
          gen_d   = '0;
          cal_d   = '0;
          emux_d  = '0;
          ecg_d   = '0;
          rtor1_d = '0;
          rtor_d  = '0;
          ovf_d   = 1'b0;
          flush   = 1'b1;
        end
        ADDR_SYNCH: begin
          ovf_d = 1'b0;
          flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      rd_sh_q     <= '0;
      miso_q      <= 1'b0;
      frame_err_q <= 1'b0;
      gen_q       <= '0;
      cal_q       <= '0;
      emux_q      <= '0;
      ecg_q       <= '0;
      rtor1_q     <= '0;
      rtor_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      rd_sh_q     <= rd_sh_d;
      miso_q      <= miso_d;
      frame_err_q <= frame_err_d;
      gen_q       <= gen_d;
      cal_q       <= cal_d;
      emux_q      <= emux_d;
      ecg_q       <= ecg_d;
      rtor1_q     <= rtor1_d;
      rtor_q      <= rtor_d;
      ovf_q       <= ovf_d;
    end
  end

  max30003_ecg_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (smp_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign miso      = miso_q;
  assign fifo_ovf  = ovf_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_max30003_spi_responder.sv
// Directed bench for max30003_spi_responder: SPI master,
// read-result scoreboard queue and flag checks.
module tb_max30003_spi_responder;

  localparam int DEPTH = 8;
  localparam int SS    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b0;
  logic          cs = 1'b1;
  logic          mosi = 1'b0;
  logic          miso;
  logic          smp_valid = 1'b0;
  logic [17:0]   smp_data = '0;
  logic          rtor_valid = 1'b0;
  logic [13:0]   rtor_data = '0;
  logic [CW-1:0] fifo_count;
  logic          fifo_ovf;
  logic          frame_err;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  logic [23:0] exp_q[$];
  logic [17:0] push_val = '0;
  logic [17:0] smp_tab[8];
  logic [23:0] dummy;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  max30003_spi_responder #(
    .FIFO_DEPTH(DEPTH),
    .SYNC_STAGES(SS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .cs         (cs),
    .mosi       (mosi),
    .miso       (miso),
    .smp_valid  (smp_valid),
    .smp_data   (smp_data),
    .rtor_valid (rtor_valid),
    .rtor_data  (rtor_data),
    .fifo_count (fifo_count),
    .fifo_ovf   (fifo_ovf),
    .frame_err  (frame_err)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // push_end: present push_val so it lands in the same cycle
  // as the pop triggered by the 32nd rising edge.
  task automatic spi_frame(input logic [7:0] cmd,
                           input logic [23:0] wd,
                           input int nbits,
                           input bit push_end,
                           output logic [23:0] rd);
    logic [31:0] fr;
    fr = {cmd, wd};
    rd = '0;
    cs = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      mosi = fr[31-i];
      wait_clk(5);
      if (i >= 8) rd = {rd[22:0], miso};
      sclk = 1'b1;
      if (push_end && i == 31) begin
        wait_clk(SS);
        smp_data  = push_val;
        smp_valid = 1'b1;
        wait_clk(1);
        smp_valid = 1'b0;
        wait_clk(4 - SS);
      end else begin
        wait_clk(5);
      end
      sclk = 1'b0;
    end
    wait_clk(6);
    cs = 1'b1;
    wait_clk(8);
  endtask

  task automatic wr(input logic [6:0] a, input logic [23:0] d);
    logic [23:0] r;
    spi_frame({a, 1'b0}, d, 32, 1'b0, r);
  endtask

  task automatic rd_chk(input logic [6:0] a, input string tag,
                        input bit push_end);
    logic [23:0] r;
    logic [23:0] e;
    spi_frame({a, 1'b1}, 24'h0, 32, push_end, r);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s observed=%0h expected=<none>", tag, r);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {8'h0, r}, {8'h0, e});
    end
  endtask

  task automatic push_smp(input logic [17:0] d);
    smp_data  = d;
    smp_valid = 1'b1;
    wait_clk(1);
    smp_valid = 1'b0;
    wait_clk(1);
  endtask

  initial begin
    wait_clk(4);
    chk("rst_miso", miso, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", fifo_ovf, 0);
    chk("rst_ferr", frame_err, 0);
    rst_n = 1'b1;
    wait_clk(4);

    wr(7'h10, 24'h081007);
    exp_q.push_back(24'h081007);
    rd_chk(7'h10, "gen_rd", 1'b0);

    push_smp(18'h00123);
    push_smp(18'h3FFFF);
    chk("cnt2", fifo_count, 2);
    exp_q.push_back(24'h0048C7);
    exp_q.push_back(24'hFFFFC7);
    exp_q.push_back(24'h000037);
    rd_chk(7'h21, "fifo_rd0", 1'b0);
    rd_chk(7'h21, "fifo_rd1", 1'b0);
    rd_chk(7'h21, "fifo_empty", 1'b0);
    chk("cnt0", fifo_count, 0);

    for (int i = 0; i < 9; i++) push_smp(18'(i + 1));
    chk("ovf_cnt", fifo_count, DEPTH);
    chk("ovf_flag", fifo_ovf, 1);
    exp_q.push_back(24'h00003F);
    rd_chk(7'h21, "ovf_rd", 1'b0);
    chk("ovf_pop_cnt", fifo_count, DEPTH - 1);
    wr(7'h09, 24'h0);
    chk("synch_cnt", fifo_count, 0);
    chk("synch_ovf", fifo_ovf, 0);

    for (int i = 0; i < 8; i++) begin
      smp_tab[i] = 18'(i * 32'h1111 + 5);
      push_smp(smp_tab[i]);
    end
    chk("full_cnt", fifo_count, DEPTH);
    push_val = 18'h2AAAA;
    exp_q.push_back({smp_tab[0], 3'b000, 3'b111});
    rd_chk(7'h21, "pp_rd", 1'b1);
    chk("pp_cnt", fifo_count, DEPTH);
    chk("pp_ovf", fifo_ovf, 0);
    for (int i = 1; i < 8; i++) begin
      exp_q.push_back({smp_tab[i], 3'b000, 3'b111});
      rd_chk(7'h21, "wrap_rd", 1'b0);
    end
    exp_q.push_back({18'h2AAAA, 3'b000, 3'b111});
    rd_chk(7'h21, "wrap_last", 1'b0);
    chk("wrap_cnt", fifo_count, 0);

    rtor_data  = 14'h0200;
    rtor_valid = 1'b1;
    wait_clk(1);
    rtor_valid = 1'b0;
    wait_clk(2);
    exp_q.push_back(24'h080000);
    rd_chk(7'h25, "rtor_rd", 1'b0);

    chk("ferr_none", fe_cnt, 0);
    spi_frame({7'h15, 1'b0}, 24'hABCDEF, 20, 1'b0, dummy);
    chk("ferr_once", fe_cnt, 1);
    exp_q.push_back(24'h000000);
    rd_chk(7'h15, "abort_nowr", 1'b0);
    wr(7'h15, 24'h123456);
    exp_q.push_back(24'h123456);
    rd_chk(7'h15, "ecg_wr", 1'b0);
    chk("ferr_stable", fe_cnt, 1);

    wr(7'h25, 24'h555555);
    exp_q.push_back(24'h080000);
    rd_chk(7'h25, "ro_ignored", 1'b0);
    exp_q.push_back(24'h000000);
    rd_chk(7'h7F, "unknown_rd", 1'b0);
    exp_q.push_back(24'h000000);
    rd_chk(7'h08, "wo_rd", 1'b0);

    push_smp(18'h00777);
    chk("pre_swrst_cnt", fifo_count, 1);
    wr(7'h08, 24'h0);
    chk("swrst_cnt", fifo_count, 0);
    exp_q.push_back(24'h000000);
    rd_chk(7'h10, "swrst_gen", 1'b0);
    exp_q.push_back(24'h000000);
    rd_chk(7'h15, "swrst_ecg", 1'b0);
    exp_q.push_back(24'h000000);
    rd_chk(7'h25, "swrst_rtor", 1'b0);
    push_smp(18'h00999);
    chk("gen_off_nopush", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
